// File: rtl/ahb_pkg.sv
// Shared AHB encodings and the master-interface FSM state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_ADDR = 2'b10,
    ST_DATA = 2'b11
  } state_e;

endpackage

// File: rtl/ahb_wait_timer.sv
// Counts consecutive hready-low cycles of a data phase and flags the
// cycle on which the stall limit is reached.
module ahb_wait_timer
  import ahb_pkg::*;
#(
  parameter int WAIT_MAX = 16
) (
  input  logic hclk,
  input  logic hresetn,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [7:0] LIMIT = 8'(WAIT_MAX - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Clear wins; otherwise count stalled cycles, saturating at the top.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)                    cnt_d = '0;
    else if (en_i && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
  end

  // Stall counter register.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  // Fires on the WAIT_MAX-th consecutive low cycle, i.e. the edge that
  // would otherwise push the count to WAIT_MAX.
  assign expired_o = en_i && (cnt_q == LIMIT);

endmodule

// File: rtl/ahb_master_interface.sv
// Single-beat AHB master: request -> grant -> address -> data, with
// wait-state handling, ERROR propagation and a data-phase stall abort.
module ahb_master_interface
  import ahb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int WAIT_MAX = 16
) (
  input  logic              hclk,
  input  logic              hresetn,
  // master request bundle
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        slv_sel_in,
  input  logic [DATA_W-1:0] din,
  input  logic              wr,
  input  logic              enable,
  input  logic              hbusreq_in,
  output logic [DATA_W-1:0] dout,
  output logic              hresp_out,
  output logic              done,
  output logic              busy,
  // AHB side
  input  logic              hgrant,
  input  logic              hready,
  input  logic              hresp,
  input  logic [DATA_W-1:0] hrdata,
  output logic              hbusreq,
  output logic [1:0]        slv_sel,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [DATA_W-1:0] hwdata
);

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q, haddr_q;
  logic [DATA_W-1:0]   din_q, hwdata_q, dout_q;
  logic                wr_q, hwrite_q, hbusreq_q, hresp_out_q, done_q, busy_q;
  logic [1:0]          sel_q, slv_sel_q, htrans_q;
  logic                tmr_clear, tmr_en, tmr_expired;

  assign tmr_en    = (state_q == ST_DATA) && !hready;
  assign tmr_clear = (state_q != ST_DATA) || hready;

  ahb_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .clear_i   (tmr_clear),
    .en_i      (tmr_en),
    .expired_o (tmr_expired)
  );

  // Transfer FSM; every bus and master-side output is a register here.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      din_q       <= '0;
      wr_q        <= 1'b0;
      sel_q       <= '0;
      haddr_q     <= '0;
      hwdata_q    <= '0;
      dout_q      <= '0;
      hwrite_q    <= 1'b0;
      slv_sel_q   <= '0;
      htrans_q    <= HTRANS_IDLE;
      hbusreq_q   <= 1'b0;
      hresp_out_q <= HRESP_OKAY;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          htrans_q  <= HTRANS_IDLE;
          hbusreq_q <= 1'b0;
          if (enable && hbusreq_in) begin
            addr_q  <= addr;
            din_q   <= din;
            wr_q    <= wr;
            sel_q   <= slv_sel_in;
            state_q <= ST_REQ;
            busy_q  <= 1'b1;
          end
        end
        ST_REQ: begin
          if (!enable || !hbusreq_in) begin
            hbusreq_q <= 1'b0;
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
          end else begin
            hbusreq_q <= 1'b1;
            // A grant only counts once our own request has been on the
            // bus for a full cycle, so a stale grant is never taken.
            if (hbusreq_q && hgrant && hready) begin
              state_q   <= ST_ADDR;
              htrans_q  <= HTRANS_NONSEQ;
              haddr_q   <= addr_q;
              hwrite_q  <= wr_q;
              slv_sel_q <= sel_q;
            end
          end
        end
        ST_ADDR: begin
          if (hready) begin
            state_q   <= ST_DATA;
            htrans_q  <= HTRANS_IDLE;
            hbusreq_q <= 1'b0;
            hwdata_q  <= wr_q ? din_q : '0;
          end
        end
        ST_DATA: begin
          if (hready || tmr_expired) begin
            done_q    <= 1'b1;
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            haddr_q   <= '0;
            hwrite_q  <= 1'b0;
            slv_sel_q <= '0;
            hwdata_q  <= '0;
            if (hready) begin
              hresp_out_q <= hresp;
              if (!wr_q && hresp == HRESP_OKAY) dout_q <= hrdata;
            end else begin
              hresp_out_q <= HRESP_ERROR;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dout      = dout_q;
  assign hresp_out = hresp_out_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign hbusreq   = hbusreq_q;
  assign slv_sel   = slv_sel_q;
  assign haddr     = haddr_q;
  assign htrans    = htrans_q;
  assign hwrite    = hwrite_q;
  assign hwdata    = hwdata_q;
  assign hsize     = HSIZE_WORD;
  assign hburst    = HBURST_SINGLE;

endmodule

// File: tb/tb_ahb_master_interface.sv
// Directed bench for ahb_master_interface: one task per scenario.
module tb_ahb_master_interface;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic [31:0] addr, din, dout, hrdata, haddr, hwdata;
  logic [1:0]  slv_sel_in, slv_sel, htrans;
  logic        wr, enable, hbusreq_in, hresp_out, done, busy;
  logic        hgrant, hready, hresp, hbusreq, hwrite;
  logic [2:0]  hsize, hburst;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 hclk = ~hclk;

  ahb_master_interface #(.ADDR_W(32), .DATA_W(32), .WAIT_MAX(16)) dut (
    .hclk(hclk), .hresetn(hresetn), .addr(addr), .slv_sel_in(slv_sel_in),
    .din(din), .wr(wr), .enable(enable), .hbusreq_in(hbusreq_in),
    .dout(dout), .hresp_out(hresp_out), .done(done), .busy(busy),
    .hgrant(hgrant), .hready(hready), .hresp(hresp), .hrdata(hrdata),
    .hbusreq(hbusreq), .slv_sel(slv_sel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata)
  );

  task automatic step();
    @(posedge hclk); #1;
  endtask

  task automatic start_req(input logic [31:0] a, input logic [31:0] d,
                           input logic w, input logic [1:0] s);
    addr = a; din = d; wr = w; slv_sel_in = s; enable = 1'b1; hbusreq_in = 1'b1;
  endtask

  task automatic test_reset();
    total_cnt++; if (htrans !== 2'b00 || hbusreq !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL rst_ctrl got htrans=%h hbusreq=%b busy=%b done=%b exp 0", htrans, hbusreq, busy, done); else pass_cnt++;
    total_cnt++; if (haddr !== 32'h0 || hwdata !== 32'h0 || dout !== 32'h0 || slv_sel !== 2'b00 || hwrite !== 1'b0 || hresp_out !== 1'b0)
      $display("FAIL rst_data got haddr=%h hwdata=%h dout=%h sel=%h exp 0", haddr, hwdata, dout, slv_sel); else pass_cnt++;
    total_cnt++; if (hsize !== 3'b010 || hburst !== 3'b000)
      $display("FAIL rst_const got hsize=%b hburst=%b exp 010/000", hsize, hburst); else pass_cnt++;
  endtask

  task automatic test_write();
    start_req(32'd2, 32'd6, 1'b1, 2'd1);
    step(); // edge0: REQ, request not yet on bus
    total_cnt++; if (busy !== 1'b1 || hbusreq !== 1'b0 || htrans !== 2'b00)
      $display("FAIL wr_e0 got busy=%b hbusreq=%b htrans=%h exp 1/0/00", busy, hbusreq, htrans); else pass_cnt++;
    step(); // edge1
    total_cnt++; if (hbusreq !== 1'b1 || htrans !== 2'b00)
      $display("FAIL wr_e1 got hbusreq=%b htrans=%h exp 1/00", hbusreq, htrans); else pass_cnt++;
    step(); // edge2: address phase
    total_cnt++; if (htrans !== 2'b10 || haddr !== 32'd2 || hwrite !== 1'b1 || slv_sel !== 2'd1)
      $display("FAIL wr_addr got htrans=%h haddr=%h hwrite=%b sel=%h exp 10/2/1/1", htrans, haddr, hwrite, slv_sel); else pass_cnt++;
    enable = 1'b0; hbusreq_in = 1'b0; addr = 32'hFF; din = 32'hFF;
    step(); // edge3: data phase
    total_cnt++; if (htrans !== 2'b00 || hwdata !== 32'd6 || done !== 1'b0 || hbusreq !== 1'b0 || slv_sel !== 2'd1)
      $display("FAIL wr_data got htrans=%h hwdata=%h done=%b hbusreq=%b sel=%h exp 00/6/0/0/1", htrans, hwdata, done, hbusreq, slv_sel); else pass_cnt++;
    step(); // edge4: complete
    total_cnt++; if (done !== 1'b1 || hresp_out !== 1'b0 || busy !== 1'b0)
      $display("FAIL wr_done got done=%b hresp_out=%b busy=%b exp 1/0/0", done, hresp_out, busy); else pass_cnt++;
    step();
    total_cnt++; if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL wr_pulse got done=%b busy=%b exp 0/0", done, busy); else pass_cnt++;
  endtask

  task automatic test_read_wait();
    start_req(32'd8, 32'h0, 1'b0, 2'd2);
    step(); step(); step(); // edge2: address phase
    total_cnt++; if (htrans !== 2'b10 || haddr !== 32'd8 || hwrite !== 1'b0)
      $display("FAIL rd_addr got htrans=%h haddr=%h hwrite=%b exp 10/8/0", htrans, haddr, hwrite); else pass_cnt++;
    enable = 1'b0; hbusreq_in = 1'b0;
    step(); // edge3: data phase
    total_cnt++; if (hwdata !== 32'h0 || slv_sel !== 2'd2)
      $display("FAIL rd_hwdata got hwdata=%h sel=%h exp 0/2", hwdata, slv_sel); else pass_cnt++;
    hready = 1'b0; hrdata = 32'hDEADBEEF;
    step(); // edge4: wait
    step(); // edge5: wait
    total_cnt++; if (done !== 1'b0 || busy !== 1'b1)
      $display("FAIL rd_wait got done=%b busy=%b exp 0/1", done, busy); else pass_cnt++;
    hready = 1'b1;
    step(); // edge6
    total_cnt++; if (done !== 1'b1 || dout !== 32'hDEADBEEF || hresp_out !== 1'b0)
      $display("FAIL rd_done got done=%b dout=%h hresp_out=%b exp 1/deadbeef/0", done, dout, hresp_out); else pass_cnt++;
    hrdata = 32'h0;
    step();
  endtask

  task automatic test_error();
    start_req(32'd4, 32'h0, 1'b0, 2'd3);
    step(); step(); step(); // edge2
    enable = 1'b0; hbusreq_in = 1'b0;
    step(); // edge3: data
    hready = 1'b0; hresp = 1'b1; hrdata = 32'h12345678;
    step(); // edge4: first ERROR cycle
    total_cnt++; if (done !== 1'b0 || htrans !== 2'b00)
      $display("FAIL err_first got done=%b htrans=%h exp 0/00", done, htrans); else pass_cnt++;
    hready = 1'b1;
    step(); // edge5
    total_cnt++; if (done !== 1'b1 || hresp_out !== 1'b1 || dout !== 32'hDEADBEEF)
      $display("FAIL err_done got done=%b hresp_out=%b dout=%h exp 1/1/deadbeef", done, hresp_out, dout); else pass_cnt++;
    hresp = 1'b0; hrdata = 32'h0;
    step();
  endtask

  task automatic test_grant_delay();
    hgrant = 1'b0;
    start_req(32'h40, 32'hA5A5, 1'b1, 2'd0);
    step(); // edge0: REQ
    for (int i = 0; i < 5; i++) begin
      step();
      total_cnt++; if (hbusreq !== 1'b1 || htrans !== 2'b00)
        $display("FAIL gnt_wait%0d got hbusreq=%b htrans=%h exp 1/00", i, hbusreq, htrans); else pass_cnt++;
    end
    hgrant = 1'b1;
    step();
    total_cnt++; if (htrans !== 2'b10 || haddr !== 32'h40)
      $display("FAIL gnt_nonseq got htrans=%h haddr=%h exp 10/40", htrans, haddr); else pass_cnt++;
    enable = 1'b0; hbusreq_in = 1'b0;
    hgrant = 1'b0; // losing grant now must not disturb the transfer
    step();
    total_cnt++; if (hwdata !== 32'hA5A5)
      $display("FAIL gnt_hwdata got %h exp a5a5", hwdata); else pass_cnt++;
    step();
    total_cnt++; if (done !== 1'b1 || hresp_out !== 1'b0)
      $display("FAIL gnt_done got done=%b hresp_out=%b exp 1/0", done, hresp_out); else pass_cnt++;
    hgrant = 1'b1;
    step();
  endtask

  task automatic test_timeout();
    start_req(32'h10, 32'h0, 1'b0, 2'd1);
    step(); step(); step(); // edge2
    enable = 1'b0; hbusreq_in = 1'b0;
    step(); // edge3: data
    hready = 1'b0; hrdata = 32'h55AA55AA;
    for (int i = 0; i < 15; i++) step();
    total_cnt++; if (done !== 1'b0 || busy !== 1'b1)
      $display("FAIL to_pre got done=%b busy=%b after 15 stalls exp 0/1", done, busy); else pass_cnt++;
    step(); // 16th stalled cycle
    total_cnt++; if (done !== 1'b1 || hresp_out !== 1'b1 || busy !== 1'b0 || dout !== 32'hDEADBEEF)
      $display("FAIL to_abort got done=%b hresp_out=%b busy=%b dout=%h exp 1/1/0/deadbeef", done, hresp_out, busy, dout); else pass_cnt++;
    hready = 1'b1; hrdata = 32'h0;
    step();
    total_cnt++; if (done !== 1'b0 || htrans !== 2'b00)
      $display("FAIL to_idle got done=%b htrans=%h exp 0/00", done, htrans); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    start_req(32'h77, 32'h99, 1'b1, 2'd3);
    step(); step(); step(); // edge2: address phase
    total_cnt++; if (htrans !== 2'b10)
      $display("FAIL ar_pre got htrans=%h exp 10", htrans); else pass_cnt++;
    #2 hresetn = 1'b0;
    #1;
    total_cnt++; if (htrans !== 2'b00 || haddr !== 32'h0 || hbusreq !== 1'b0 || busy !== 1'b0 || slv_sel !== 2'b00 || hwrite !== 1'b0)
      $display("FAIL ar_ctrl got htrans=%h haddr=%h hbusreq=%b busy=%b sel=%h hwrite=%b exp 0", htrans, haddr, hbusreq, busy, slv_sel, hwrite); else pass_cnt++;
    total_cnt++; if (dout !== 32'h0 || hresp_out !== 1'b0 || done !== 1'b0 || hwdata !== 32'h0)
      $display("FAIL ar_data got dout=%h hresp_out=%b done=%b hwdata=%h exp 0", dout, hresp_out, done, hwdata); else pass_cnt++;
    enable = 1'b0; hbusreq_in = 1'b0;
    step();
    hresetn = 1'b1;
    step();
  endtask

  task automatic test_req_abort();
    hgrant = 1'b0;
    start_req(32'h20, 32'h1, 1'b1, 2'd1);
    step(); step(); // in REQ, request on bus
    total_cnt++; if (busy !== 1'b1 || hbusreq !== 1'b1)
      $display("FAIL ab_req got busy=%b hbusreq=%b exp 1/1", busy, hbusreq); else pass_cnt++;
    enable = 1'b0;
    step();
    total_cnt++; if (busy !== 1'b0 || hbusreq !== 1'b0 || done !== 1'b0)
      $display("FAIL ab_idle got busy=%b hbusreq=%b done=%b exp 0/0/0", busy, hbusreq, done); else pass_cnt++;
    hgrant = 1'b1;
    step();
    total_cnt++; if (done !== 1'b0 || busy !== 1'b0 || htrans !== 2'b00)
      $display("FAIL ab_after got done=%b busy=%b htrans=%h exp 0/0/00", done, busy, htrans); else pass_cnt++;
    hbusreq_in = 1'b0;
  endtask

  initial begin
    hresetn = 1'b0;
    addr = '0; din = '0; wr = 1'b0; slv_sel_in = '0; enable = 1'b0; hbusreq_in = 1'b0;
    hgrant = 1'b1; hready = 1'b1; hresp = 1'b0; hrdata = '0;
    #12 hresetn = 1'b1;
    step();
    test_reset();
    test_write();
    test_read_wait();
    test_error();
    test_grant_delay();
    test_timeout();
    test_async_reset();
    test_req_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "bench timeout");
  end

endmodule
